// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int AXI_DWIDTH_DEF = 32;
    localparam int STRB_W         = AXI_DWIDTH_DEF / 8;
    localparam int MAX_DWIDTH     = 64;
    localparam int MAX_STRB       = MAX_DWIDTH / 8;

    // Byte-wise merge at the widest supported bus; callers zero-extend and truncate.
    function automatic logic [MAX_DWIDTH-1:0] byte_merge(
        input logic [MAX_DWIDTH-1:0] old_d,
        input logic [MAX_DWIDTH-1:0] new_d,
        input logic [MAX_STRB-1:0]   strb
    );
        logic [MAX_DWIDTH-1:0] res;
        res = old_d;
        for (int k = 0; k < MAX_STRB; k++) begin
            if (strb[k]) res[8*k +: 8] = new_d[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry valid/ready holding register used for the AW and W channels.
module axil_hold_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_clear,
    output logic         o_full,
    output logic [W-1:0] o_data
);
    logic         r_full;
    logic [W-1:0] r_data;

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // Capture on handshake; the consumer empties the slot via i_clear.
    // Clear and capture never coincide since ready is low while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave backed by NUM_REGS data-width registers with strobe merging,
// address decode (SLVERR on miss) and registered B/R responses.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int                    AXI_AWIDTH = 12,
    parameter int                    AXI_DWIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [AXI_AWIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [AXI_AWIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    input  logic [2:0]                     AWPROT,
    output logic                           AWREADY,
    input  logic [AXI_DWIDTH-1:0]          WDATA,
    input  logic [AXI_DWIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [AXI_AWIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    input  logic [2:0]                     ARPROT,
    output logic                           ARREADY,
    output logic [AXI_DWIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*AXI_DWIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int SW  = AXI_DWIDTH / 8;
    localparam int BSH = $clog2(SW);

    logic                  w_aw_full, w_w_full, w_commit, w_arready;
    logic [AXI_AWIDTH-1:0] w_aw_addr, w_aw_idx, w_ar_idx;
    logic                  w_aw_hit, w_ar_hit;
    logic [AXI_DWIDTH-1:0] w_wdata, w_rd_word;
    logic [SW-1:0]         w_wstrb;
    logic [NUM_REGS-1:0]   w_sel;
    logic                  w_unused;

    logic [NUM_REGS-1:0][AXI_DWIDTH-1:0] r_regs, w_merged;
    logic [NUM_REGS-1:0]                 r_pulse;
    logic                                r_bvalid, r_rvalid;
    resp_t                               r_bresp, r_rresp;
    logic [AXI_DWIDTH-1:0]               r_rdata;

    function automatic logic [AXI_AWIDTH-1:0] f_idx(input logic [AXI_AWIDTH-1:0] a);
        return (a - BASE_ADDR) >> BSH;
    endfunction

    function automatic logic f_hit(input logic [AXI_AWIDTH-1:0] a);
        return (a >= BASE_ADDR) && (32'(f_idx(a)) < NUM_REGS);
    endfunction

    axil_hold_slot #(.W(AXI_AWIDTH)) u_aw_slot (
        .clk(clk), .rst_n(rst_n), .i_valid(AWVALID), .o_ready(AWREADY),
        .i_data(AWADDR), .i_clear(w_commit), .o_full(w_aw_full), .o_data(w_aw_addr)
    );

    axil_hold_slot #(.W(AXI_DWIDTH + SW)) u_w_slot (
        .clk(clk), .rst_n(rst_n), .i_valid(WVALID), .o_ready(WREADY),
        .i_data({WDATA, WSTRB}), .i_clear(w_commit), .o_full(w_w_full),
        .o_data({w_wdata, w_wstrb})
    );

    assign w_commit  = w_aw_full && w_w_full && (!r_bvalid || BREADY);
    assign w_aw_idx  = f_idx(w_aw_addr);
    assign w_aw_hit  = f_hit(w_aw_addr);
    assign w_ar_idx  = f_idx(ARADDR);
    assign w_ar_hit  = f_hit(ARADDR);
    assign w_arready = !r_rvalid || RREADY;
    assign w_unused  = &{1'b0, AWPROT, ARPROT};

    assign ARREADY  = w_arready;
    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign RVALID   = r_rvalid;
    assign RDATA    = r_rdata;
    assign RRESP    = r_rresp;
    assign reg_q    = r_regs;
    assign wr_pulse = r_pulse;

    // Per-register write select and strobe-merged next value.
    always_comb begin
        w_sel    = '0;
        w_merged = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_sel[i]    = w_commit && w_aw_hit && (w_aw_idx == AXI_AWIDTH'(i));
            w_merged[i] = AXI_DWIDTH'(byte_merge(64'(r_regs[i]), 64'(w_wdata), 8'(w_wstrb)));
        end
    end

    // Read mux over the register array (pre-edge contents).
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == AXI_AWIDTH'(i)) w_rd_word = r_regs[i];
        end
    end

    // Register storage and one-cycle write pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= w_sel;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_sel[i]) r_regs[i] <= w_merged[i];
            end
        end
    end

    // Write response: a commit (re)loads BVALID, otherwise BREADY drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bvalid <= 1'b0;
            r_bresp  <= OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            if (w_aw_hit) r_bresp <= OKAY;
            else          r_bresp <= SLVERR;
        end else if (BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read response: AR handshake loads data, otherwise RREADY drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (ARVALID && w_arready) begin
            r_rvalid <= 1'b1;
            if (w_ar_hit) begin
                r_rdata <= w_rd_word;
                r_rresp <= OKAY;
            end else begin
                r_rdata <= '0;
                r_rresp <= SLVERR;
            end
        end else if (RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
- Parametrised AXI4-Lite slave terminating one AXI-Lite port in a local register file of NUM_REGS words.
- Successor to the plain AXI-Lite bundle: adds independent AW/W acceptance, byte-strobe merging, address decode with SLVERR, and registered read/write responses.
- Sits behind the global-controller AXI-Lite master and drives flat config outputs plus per-register write pulses to downstream logic.

Parameters:
- AXI_AWIDTH, 12, address width in bits.
- AXI_DWIDTH, 32, data width in bits; must be 32 or 64.
- NUM_REGS, 16, number of data-width registers; 1..2^(AXI_AWIDTH-log2(AXI_DWIDTH/8)).
- BASE_ADDR, 0, byte address of register 0; aligned to AXI_DWIDTH/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- AWADDR  in  AXI_AWIDTH  write address
- AWVALID  in  1  write address valid
- AWPROT  in  3  ignored
- AWREADY  out  1  write address ready
- WDATA  in  AXI_DWIDTH  write data
- WSTRB  in  AXI_DWIDTH/8  byte strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  AXI_AWIDTH  read address
- ARVALID  in  1  read address valid
- ARPROT  in  3  ignored
- ARREADY  out  1  read address ready
- RDATA  out  AXI_DWIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- reg_q  out  NUM_REGS*AXI_DWIDTH  register contents; reg i at bits [i*AXI_DWIDTH +: AXI_DWIDTH]
- wr_pulse  out  NUM_REGS  one-cycle pulse on a successful write to reg i

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all registers 0; AWREADY=1; WREADY=1; BVALID=0; BRESP=0; ARREADY=1; RVALID=0; RDATA=0; RRESP=0; wr_pulse=0.
- Reset mid-transaction drops all held/pending transactions silently.
- Address decode:
  - off = ADDR - BASE_ADDR, unsigned, AXI_AWIDTH bits with wrap.
  - idx = off >> log2(AXI_DWIDTH/8); low byte-offset bits are ignored.
  - Hit iff ADDR >= BASE_ADDR and idx < NUM_REGS.
- Write acceptance:
  - AW and W each have a one-entry holding slot (aw_full, w_full).
  - AWREADY = !aw_full; WREADY = !w_full.
  - Either may arrive first, or both in the same cycle.
  - Handshake on a channel sets its slot on that edge.
- Write commit:
  - Fires when aw_full && w_full && (!BVALID || BREADY).
  - On the commit edge: clear both slots. On a hit, reg[idx] byte k <= WDATA byte k where WSTRB[k]=1; wr_pulse[idx]=1 for exactly the next cycle. On a miss, no register changes and no pulse.
  - BVALID=1 from the commit edge, with BRESP=2'b00 (OKAY) on a hit or 2'b10 (SLVERR) on a miss.
  - WSTRB=0 on a hit gives OKAY and a pulse but no data change.
- Write latency: AW+W accepted at edge N, commit at edge N+1, BVALID visible after N+1.
- Write response: BVALID/BRESP hold until BREADY. BVALID&&BREADY at edge M with no new commit clears BVALID. A commit at the same edge reloads BVALID=1 (back-to-back allowed).
- Read path:
  - ARREADY = !RVALID || RREADY.
  - On AR handshake at edge N: RVALID=1 after N; RDATA = reg[idx] sampled pre-edge, RRESP=OKAY on a hit; RDATA=0, RRESP=SLVERR on a miss.
  - RDATA/RRESP stay stable while RVALID && !RREADY.
  - RVALID&&RREADY with no new AR clears RVALID. Simultaneous RREADY and a new AR reloads (one read per cycle sustained).
- Simultaneous events:
  - Read and write commit to the same reg on the same edge: read returns the old value.
  - Read and write paths are fully independent.

Decomposition:
- Shared package axil_pkg: resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), localparam STRB_W = AXI_DWIDTH/8, function for the byte-merge of old data with new data under a strobe mask.
- Sub-module axil_hold_slot: a parametrised one-entry valid/ready holding register. It is instantiated twice, once for AW (addr) and once for W (data+strobe).

Test Plan:
- Reset, then AW=0x008 and W=0xDEADBEEF with WSTRB=0xF in the same cycle, BREADY=1 -> BVALID two edges later, BRESP=00, reg_q[2]=0xDEADBEEF, wr_pulse=0x0004 for one cycle.
- W sent 3 cycles before AW=0x004, WDATA=0x12345678, WSTRB=0x5, reg1 preset 0xFFFFFFFF -> reg1=0xFF34FF78, WREADY=0 until commit.
- Write to AWADDR=0x040 (idx16, NUM_REGS=16) -> BRESP=10, no reg change, wr_pulse=0; read of ARADDR=0x040 -> RRESP=10, RDATA=0.
- BREADY held 0 for 5 cycles after the first write while a second AW/W pair is presented -> second pair accepted into slots, BVALID/BRESP stable, second commit on the edge BREADY rises, BVALID stays 1.
- ARVALID=1 continuously on 0x000,0x004,0x008 with RREADY=1 -> one RVALID beat per cycle with the correct data; RREADY=0 for 2 cycles -> ARREADY=0 and RDATA held.
- rst_n asserted asynchronously mid-cycle with AW held and RVALID=1 -> all outputs immediately at reset values; the held AW is dropped and no commit follows deassertion.
